// File: rtl/fma16_tv_pkg.sv
// Shared types, constants and the byte-index to ASCII character mapping
// for the fma16 test-vector line writer.
package fma16_tv_pkg;

  // One captured fma16 operation (76 bits).
  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
    logic [15:0] z;
    logic [7:0]  ctrl;
    logic [15:0] result;
    logic [3:0]  flags;
  } tv_rec_t;

  localparam int unsigned LINE_CHARS = 25;
  localparam logic [4:0]  LAST_IDX   = 5'(LINE_CHARS - 1);
  localparam logic [7:0]  ASCII_US   = 8'h5F;
  localparam logic [7:0]  ASCII_NL   = 8'h0A;

  typedef enum logic {
    StIdle,
    StEmit
  } tv_state_e;

  // Lowercase hex digit for one nibble.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h57 + {4'h0, nib};
  endfunction

  // Character at position idx of the line for rec:
  // xxxx_yyyy_zzzz_cc_rrrr_f\n, MSB nibble first.
  function automatic logic [7:0] tv_char(input tv_rec_t rec, input logic [4:0] idx);
    logic [3:0] nib;
    logic       is_hex;
    logic [7:0] sep;
    nib    = 4'h0;
    is_hex = 1'b1;
    sep    = ASCII_US;
    case (idx)
      5'd0:  nib = rec.x[15:12];
      5'd1:  nib = rec.x[11:8];
      5'd2:  nib = rec.x[7:4];
      5'd3:  nib = rec.x[3:0];
      5'd5:  nib = rec.y[15:12];
      5'd6:  nib = rec.y[11:8];
      5'd7:  nib = rec.y[7:4];
      5'd8:  nib = rec.y[3:0];
      5'd10: nib = rec.z[15:12];
      5'd11: nib = rec.z[11:8];
      5'd12: nib = rec.z[7:4];
      5'd13: nib = rec.z[3:0];
      5'd15: nib = rec.ctrl[7:4];
      5'd16: nib = rec.ctrl[3:0];
      5'd18: nib = rec.result[15:12];
      5'd19: nib = rec.result[11:8];
      5'd20: nib = rec.result[7:4];
      5'd21: nib = rec.result[3:0];
      5'd23: nib = rec.flags;
      5'd4, 5'd9, 5'd14, 5'd17, 5'd22: is_hex = 1'b0;
      default: begin
        is_hex = 1'b0;
        sep    = ASCII_NL;
      end
    endcase
    return is_hex ? hex_ascii(nib) : sep;
  endfunction

endpackage

// File: rtl/fma16_tv_fifo.sv
// Synchronous FIFO of test-vector records. Exposes the head entry and the
// entry behind it so the writer can start the next line without a bubble.
module fma16_tv_fifo
  import fma16_tv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    push,
  input  tv_rec_t wdata,
  input  logic    pop,
  output tv_rec_t head,
  output tv_rec_t head_next,
  output logic    has_next,
  output logic    full,
  output logic    empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  tv_rec_t         mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q, rd_ptr_next;
  logic [CW-1:0]   count_q, count_d;
  logic            push_en, pop_en;

  assign full        = (count_q == CW'(DEPTH));
  assign empty       = (count_q == '0);
  assign has_next    = (count_q > CW'(1));
  assign push_en     = push && !full;
  assign pop_en      = pop && !empty;
  assign rd_ptr_next = rd_ptr_q + AW'(1);
  assign head        = mem_q[rd_ptr_q];
  assign head_next   = mem_q[rd_ptr_next];

  // Occupancy: simultaneous push and pop leaves the count unchanged.
  always_comb begin
    count_d = count_q;
    if (push_en && !pop_en) begin
      count_d = count_q + CW'(1);
    end else if (!push_en && pop_en) begin
      count_d = count_q - CW'(1);
    end
  end

  // Record storage; contents need no reset since empty gates all reads.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (pop_en) begin
        rd_ptr_q <= rd_ptr_next;
      end
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fma16_tv_writer.sv
// Captures fma16 operand/result records and streams each one as a
// 25-character ASCII test-vector line over a valid/ready byte interface.
module fma16_tv_writer
  import fma16_tv_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic [15:0] z,
  input  logic [7:0]  ctrl,
  input  logic [15:0] result,
  input  logic [3:0]  flags,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        busy,
  output logic [31:0] lines_written
);

  tv_rec_t   in_rec, head, head_next;
  logic      push, pop, full, empty, has_next, accept;

  tv_state_e state_q, state_d;
  logic [4:0]  idx_q, idx_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic [31:0] lines_q, lines_d;

  assign in_rec = '{x: x, y: y, z: z, ctrl: ctrl, result: result, flags: flags};

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign accept   = out_valid_q && out_ready;

  fma16_tv_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .wdata    (in_rec),
    .pop      (pop),
    .head     (head),
    .head_next(head_next),
    .has_next (has_next),
    .full     (full),
    .empty    (empty)
  );

  // Next-state: idx_q is the position of the byte currently on out_data.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    lines_d     = lines_q;
    pop         = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!empty) begin
          state_d     = StEmit;
          idx_d       = '0;
          out_valid_d = 1'b1;
          out_data_d  = tv_char(head, 5'd0);
        end
      end
      StEmit: begin
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            pop     = 1'b1;
            lines_d = lines_q + 32'd1;
            idx_d   = '0;
            // Load the following record straight away to avoid a bubble;
            // when the head is the only entry, a same-cycle push is bypassed.
            if (has_next) begin
              out_data_d = tv_char(head_next, 5'd0);
            end else if (push) begin
              out_data_d = tv_char(in_rec, 5'd0);
            end else begin
              state_d     = StIdle;
              out_valid_d = 1'b0;
            end
          end else begin
            idx_d      = idx_q + 5'd1;
            out_data_d = tv_char(head, idx_q + 5'd1);
          end
        end
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'h00;
      lines_q     <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      lines_q     <= lines_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign out_data      = out_data_q;
  assign lines_written = lines_q;
  assign busy          = !empty || (state_q == StEmit);

endmodule

// File: tb/tb_fma16_tv_writer.sv
// Directed bench for fma16_tv_writer: expected lines are literal strings or
// built with $sformatf, accepted bytes are captured by a negedge monitor.
module tb_fma16_tv_writer;
  import fma16_tv_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] x = '0, y = '0, z = '0, result = '0;
  logic [7:0]  ctrl = '0;
  logic [3:0]  flags = '0;
  logic        in_ready, out_valid, busy;
  logic [7:0]  out_data;
  logic [31:0] lines_written;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_lines = 0;
  int last_push_cyc = 0;
  logic [7:0] q_bytes[$];
  int         q_cyc[$];
  int         stall_viol = 0;
  int         stall_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  fma16_tv_writer #(
    .DEPTH(DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .x            (x),
    .y            (y),
    .z            (z),
    .ctrl         (ctrl),
    .result       (result),
    .flags        (flags),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .busy         (busy),
    .lines_written(lines_written)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Byte capture and stall-stability watch, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      q_bytes.push_back(out_data);
      q_cyc.push_back(cyc);
    end
    if (reset && prev_stall && out_valid && (out_data !== prev_data)) begin
      stall_viol <= stall_viol + 1;
    end
    if (reset && out_valid && !out_ready) begin
      stall_cnt <= stall_cnt + 1;
    end
    prev_stall <= reset && out_valid && !out_ready;
    prev_data  <= out_data;
  end

  function automatic string fmt(input tv_rec_t r);
    return $sformatf("%04h_%04h_%04h_%02h_%04h_%01h\n",
                     r.x, r.y, r.z, r.ctrl, r.result, r.flags);
  endfunction

  function automatic string got_line(input int start);
    string s = "";
    for (int i = 0; i < 25; i++) begin
      if (start + i < q_bytes.size()) s = $sformatf("%s%c", s, q_bytes[start + i]);
    end
    return s;
  endfunction

  function automatic string vis(input string s);
    string r = "";
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h0A) r = $sformatf("%s\\n", r);
      else r = $sformatf("%s%c", r, s[i]);
    end
    return r;
  endfunction

  // Offer one record and hold it until accepted (bounded).
  task automatic push_rec(input tv_rec_t r);
    int n = 0;
    x = r.x; y = r.y; z = r.z; ctrl = r.ctrl; result = r.result; flags = r.flags;
    in_valid = 1'b1;
    while (!in_ready && n < 400) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL push_timeout in_ready=%0b required=1", in_ready);
    end else begin
      @(posedge clk); #1;
      last_push_cyc = cyc;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_bytes(input int target);
    int n = 0;
    while (q_bytes.size() < target && n < 3000) begin
      @(posedge clk); #1; n++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data got=%02h exp=00", out_data); end
    checks++; if (lines_written !== 32'd0) begin errors++; $display("FAIL reset_lines got=%0d exp=0", lines_written); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
    reset = 1'b1;
    exp_lines = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_line();
    tv_rec_t r = '{x: 16'h3c00, y: 16'h4000, z: 16'h0000, ctrl: 8'h08, result: 16'h4000, flags: 4'h0};
    string exp = "3c00_4000_0000_08_4000_0\n";
    string got;
    int base = q_bytes.size();
    out_ready = 1'b1;
    push_rec(r);
    wait_bytes(base + 25);
    exp_lines++;
    got = got_line(base);
    checks++; if (got != exp) begin errors++; $display("FAIL basic_line got=%s exp=%s", vis(got), vis(exp)); end
    checks++; if (q_cyc[base] !== last_push_cyc + 1) begin errors++; $display("FAIL basic_latency got=%0d exp=%0d", q_cyc[base], last_push_cyc + 1); end
    checks++; if (q_cyc[base + 24] - q_cyc[base] !== 24) begin errors++; $display("FAIL basic_consecutive span got=%0d exp=24", q_cyc[base + 24] - q_cyc[base]); end
    checks++; if (lines_written !== 32'(exp_lines)) begin errors++; $display("FAIL basic_lines got=%0d exp=%0d", lines_written, exp_lines); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got=%0b exp=0", busy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_after got=%0b exp=0", out_valid); end
  endtask

  task automatic test_lowercase();
    tv_rec_t r = '{x: 16'habcd, y: 16'hef01, z: 16'h0000, ctrl: 8'h0f, result: 16'hffff, flags: 4'hf};
    string exp = "abcd_ef01_0000_0f_ffff_f\n";
    string got;
    int base = q_bytes.size();
    out_ready = 1'b1;
    push_rec(r);
    wait_bytes(base + 25);
    exp_lines++;
    got = got_line(base);
    checks++; if (got != exp) begin errors++; $display("FAIL lowercase_line got=%s exp=%s", vis(got), vis(exp)); end
    checks++; if (q_bytes[base] !== 8'h61) begin errors++; $display("FAIL lowercase_a got=%02h exp=61", q_bytes[base]); end
    checks++; if (lines_written !== 32'(exp_lines)) begin errors++; $display("FAIL lowercase_lines got=%0d exp=%0d", lines_written, exp_lines); end
  endtask

  task automatic test_stall();
    tv_rec_t r[2];
    string got, exp;
    int base = q_bytes.size();
    int viol0 = stall_viol;
    int stall0 = stall_cnt;
    int n = 0;
    r[0] = '{x: 16'h3c00, y: 16'h4000, z: 16'h0000, ctrl: 8'h08, result: 16'h4000, flags: 4'h0};
    r[1] = '{x: 16'h1234, y: 16'h5678, z: 16'h9abc, ctrl: 8'h3d, result: 16'hdef0, flags: 4'h7};
    out_ready = 1'b0;
    push_rec(r[0]);
    push_rec(r[1]);
    while (q_bytes.size() < base + 50 && n < 2000) begin
      out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1; n++;
    end
    out_ready = 1'b1;
    wait_bytes(base + 50);
    exp_lines += 2;
    for (int k = 0; k < 2; k++) begin
      got = got_line(base + 25 * k);
      exp = fmt(r[k]);
      checks++; if (got != exp) begin errors++; $display("FAIL stall_line%0d got=%s exp=%s", k, vis(got), vis(exp)); end
    end
    checks++; if (stall_viol - viol0 !== 0) begin errors++; $display("FAIL stall_stable changes=%0d exp=0", stall_viol - viol0); end
    checks++; if (stall_cnt == stall0) begin errors++; $display("FAIL stall_seen stalls=%0d exp=>0", stall_cnt - stall0); end
    checks++; if (lines_written !== 32'(exp_lines)) begin errors++; $display("FAIL stall_lines got=%0d exp=%0d", lines_written, exp_lines); end
  endtask

  task automatic test_backpressure();
    tv_rec_t r[5];
    string got, exp;
    int base = q_bytes.size();
    int n = 0;
    for (int k = 0; k < 5; k++) begin
      r[k] = '{x: 16'(16'h1111 * (k + 1)), y: 16'(16'h0f0f + k), z: 16'(16'hc000 | k),
               ctrl: 8'(8'h10 + k), result: 16'(16'h8000 + 16'h0101 * k), flags: 4'(k + 3)};
    end
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_rec(r[k]);
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_after4 in_ready=%0b exp=0", in_ready); end
    x = r[4].x; y = r[4].y; z = r[4].z; ctrl = r[4].ctrl; result = r[4].result; flags = r[4].flags;
    in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold in_ready=%0b exp=0", in_ready); end
    out_ready = 1'b1;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    checks++; if (q_bytes.size() - base !== 25) begin errors++; $display("FAIL bp_ready_at_nl bytes=%0d exp=25", q_bytes.size() - base); end
    checks++; if (q_bytes[base + 24] !== 8'h0A) begin errors++; $display("FAIL bp_nl_byte got=%02h exp=0a", q_bytes[base + 24]); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_bytes(base + 100);
    checks++; if (q_bytes.size() - base !== 100) begin errors++; $display("FAIL bp_100 bytes=%0d exp=100", q_bytes.size() - base); end
    checks++; if (lines_written !== 32'(exp_lines + 4)) begin errors++; $display("FAIL bp_lines4 got=%0d exp=%0d", lines_written, exp_lines + 4); end
    wait_bytes(base + 125);
    exp_lines += 5;
    for (int k = 0; k < 5; k++) begin
      got = got_line(base + 25 * k);
      exp = fmt(r[k]);
      checks++; if (got != exp) begin errors++; $display("FAIL bp_line%0d got=%s exp=%s", k, vis(got), vis(exp)); end
    end
  endtask

  task automatic test_reset_midline();
    tv_rec_t ra = '{x: 16'haaaa, y: 16'h1111, z: 16'h2222, ctrl: 8'h01, result: 16'h3333, flags: 4'h1};
    tv_rec_t rb = '{x: 16'hbbbb, y: 16'h4444, z: 16'h5555, ctrl: 8'h02, result: 16'h6666, flags: 4'h2};
    tv_rec_t rc = '{x: 16'hcccc, y: 16'h7777, z: 16'h8888, ctrl: 8'h04, result: 16'h9999, flags: 4'h4};
    tv_rec_t rd = '{x: 16'h0123, y: 16'h4567, z: 16'h89ab, ctrl: 8'hcd, result: 16'hef00, flags: 4'h9};
    string got, exp;
    int base = q_bytes.size();
    int mark;
    out_ready = 1'b1;
    push_rec(ra);
    push_rec(rb);
    push_rec(rc);
    wait_bytes(base + 11);
    reset = 1'b0;
    @(posedge clk); #1;
    exp_lines = 0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid got=%0b exp=0", out_valid); end
    checks++; if (lines_written !== 32'd0) begin errors++; $display("FAIL rst_mid_lines got=%0d exp=0", lines_written); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got=%0b exp=0", busy); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got=%0b exp=1", in_ready); end
    reset = 1'b1;
    mark = q_bytes.size();
    repeat (40) @(posedge clk);
    #1;
    checks++; if (q_bytes.size() !== mark) begin errors++; $display("FAIL rst_mid_stale bytes=%0d exp=0", q_bytes.size() - mark); end
    push_rec(rd);
    wait_bytes(mark + 25);
    exp_lines++;
    got = got_line(mark);
    exp = "0123_4567_89ab_cd_ef00_9\n";
    checks++; if (got != exp) begin errors++; $display("FAIL rst_mid_clean got=%s exp=%s", vis(got), vis(exp)); end
    checks++; if (lines_written !== 32'(exp_lines)) begin errors++; $display("FAIL rst_mid_lines_after got=%0d exp=%0d", lines_written, exp_lines); end
  endtask

  task automatic test_back_to_back();
    tv_rec_t r[8];
    string got, exp;
    int base = q_bytes.size();
    int gaps = 0;
    for (int k = 0; k < 8; k++) begin
      r[k] = '{x: 16'(16'h1000 * k + 16'h00a5), y: 16'(16'hffff - k), z: 16'(16'h0f00 + 16'h0011 * k),
               ctrl: 8'(8'h20 + k), result: 16'(16'h7c00 - k), flags: 4'(15 - k)};
    end
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) push_rec(r[k]);
    wait_bytes(base + 200);
    exp_lines += 8;
    for (int k = 0; k < 8; k++) begin
      got = got_line(base + 25 * k);
      exp = fmt(r[k]);
      checks++; if (got != exp) begin errors++; $display("FAIL b2b_line%0d got=%s exp=%s", k, vis(got), vis(exp)); end
    end
    for (int i = 1; i < 200; i++) begin
      if (q_cyc[base + i] != q_cyc[base + i - 1] + 1) gaps++;
    end
    checks++; if (gaps !== 0) begin errors++; $display("FAIL b2b_gaps got=%0d exp=0", gaps); end
    checks++; if (lines_written !== 32'(exp_lines)) begin errors++; $display("FAIL b2b_lines got=%0d exp=%0d", lines_written, exp_lines); end
  endtask

  initial begin
    test_reset();
    test_basic_line();
    test_lowercase();
    test_stall();
    test_backpressure();
    test_reset_midline();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/fma16_tv_writer.md
FMA16_TV_WRITER -- requirements
Module: fma16_tv_writer

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- DEPTH, 4, record FIFO entries (power of 2, >= 2)
REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, clock
- reset, in, 1, synchronous active-low reset
- in_valid, in, 1, capture record offered
- in_ready, out, 1, record FIFO can accept
- x, in, 16, operand x
- y, in, 16, operand y
- z, in, 16, operand z
- ctrl, in, 8, control byte {2'b0, roundmode[1:0], mul, add, negp, negz}
- result, in, 16, fma16 result
- flags, in, 4, {invalid, overflow, underflow, inexact}
- out_valid, out, 1, ASCII byte available
- out_ready, in, 1, sink accepts byte
- out_data, out, 8, ASCII byte
- busy, out, 1, FIFO non-empty or line in progress
- lines_written, out, 32, completed lines (newline accepted)

Function
REQ-003 A record is pushed when in_valid && in_ready; in_ready SHALL equal !fifo_full (no same-cycle pass-through when full).
REQ-004 Each record SHALL serialize to exactly 25 bytes: 4 hex x, '_', 4 hex y, '_', 4 hex z, '_', 2 hex ctrl, '_', 4 hex result, '_', 1 hex flags, '\n' (0x0A); '_' is 0x5F.
REQ-005 Hex digits SHALL be MSB nibble first; 0-9 -> 0x30-0x39, a-f -> 0x61-0x66 (lowercase).
REQ-006 FSM states IDLE, EMIT; IDLE->EMIT when FIFO non-empty; EMIT->IDLE when byte index 24 is accepted and FIFO will be empty, else stays EMIT with index reset to 0 and the next record loaded.
REQ-007 Byte index counter 0..24 SHALL advance only on out_valid && out_ready; it wraps to 0 after 24.
REQ-008 out_data and out_valid SHALL be registered; out_data SHALL hold stable while out_valid && !out_ready.
REQ-009 First byte of a record SHALL appear on out_valid 2 cycles after its push into an empty FIFO in IDLE (push edge, load edge).
REQ-010 With out_ready held high, bytes SHALL stream at one per cycle, including back-to-back across record boundaries (no bubble).
REQ-011 The FIFO entry SHALL be popped when its '\n' byte is accepted; simultaneous push and pop SHALL both take effect.
REQ-012 lines_written SHALL increment by 1 on each accepted '\n'; it wraps modulo 2^32.
REQ-013 busy = FIFO non-empty || state == EMIT.

Reset
REQ-014 On clk edge with reset == 0: FIFO emptied, state IDLE, index 0, out_valid 0, out_data 8'h00, lines_written 0; in_ready reads 1 the cycle after.
REQ-015 Reset mid-line SHALL discard the partial line and all queued records; no further bytes of them are emitted.

Structure
REQ-016 Package fma16_tv_pkg SHALL hold: record struct tv_rec_t {x, y, z, ctrl, result, flags} (76 bits), LINE_CHARS = 25, ASCII_US = 8'h5F, ASCII_NL = 8'h0A, state enum.
REQ-017 Record storage SHALL be one sub-module fma16_tv_fifo (sync FIFO of tv_rec_t, DEPTH entries, full/empty flags).
REQ-018 Field-to-nibble selection SHALL be a combinational function of byte index in fma16_tv_pkg.

Verification
REQ-019 Push {3c00,4000,0000,08,4000,0}, out_ready = 1 -> bytes "3c00_4000_0000_08_4000_0\n" on 25 consecutive cycles, lines_written = 1, busy drops after the '\n'.
REQ-020 Push {abcd,ef01,0000,0f,ffff,f} -> "abcd_ef01_0000_0f_ffff_f\n" (lowercase 0x61-0x66 checked).
REQ-021 out_ready toggled randomly 50% -> identical byte sequence; out_data stable during every stall.
REQ-022 out_ready = 0, push 5 records with DEPTH = 4 -> in_ready low after the 4th; 5th accepted only after the first '\n' is accepted; 100 bytes out in order, lines_written = 4 before the 5th line starts.
REQ-023 Reset asserted after byte 10 of a line with 2 records queued -> out_valid 0 next cycle, lines_written 0, no stale bytes after release; a new record emits a clean line.
REQ-024 Continuous push with out_ready = 1 for 8 records -> 200 bytes with no idle cycle between lines.
